// File: rtl/cpu_8bit_pkg.sv
// rtl/cpu_8bit_pkg.sv - opcodes, field positions and widths for the 8-bit accumulator core
package cpu_8bit_pkg;

    localparam int DATA_W = 8;
    localparam int REG_N  = 8;

    localparam int OP_MSB = 7;
    localparam int OP_LSB = 4;
    localparam int D_BIT  = 3;
    localparam int N_MSB  = 2;
    localparam int IMM_MSB = 3;

    localparam logic [3:0] OP_MOV   = 4'h0;
    localparam logic [3:0] OP_LDI   = 4'h1;
    localparam logic [3:0] OP_LDH   = 4'h2;
    localparam logic [3:0] OP_NOT   = 4'h3;
    localparam logic [3:0] OP_ADD   = 4'h4;
    localparam logic [3:0] OP_SUB   = 4'h5;
    localparam logic [3:0] OP_AND   = 4'h6;
    localparam logic [3:0] OP_OR    = 4'h7;
    localparam logic [3:0] OP_XOR   = 4'h8;
    localparam logic [3:0] OP_SHIFT = 4'h9;
    localparam logic [3:0] OP_INC   = 4'hA;
    localparam logic [3:0] OP_DEC   = 4'hB;
    localparam logic [3:0] OP_NOP   = 4'hC;

endpackage

// File: rtl/cpu_8bit_alu.sv
// rtl/cpu_8bit_alu.sv - combinational ALU producing the new accumulator value and flags
module cpu_8bit_alu
    import cpu_8bit_pkg::*;
(
    input  logic [3:0]        op,
    input  logic              d,
    input  logic [DATA_W-1:0] c,
    input  logic [DATA_W-1:0] r,
    input  logic              cf_in,
    output logic [DATA_W-1:0] result,
    output logic              cf_out,
    output logic              zf_out,
    output logic              c_we,
    output logic              flags_we
);

    logic [DATA_W:0] wide;

    always_comb begin
        result   = c;
        cf_out   = cf_in;
        c_we     = 1'b0;
        flags_we = 1'b0;
        wide     = '0;
        case (op)
            OP_MOV: begin
                result = r;
                c_we   = ~d;
            end
            OP_NOT: begin
                result   = ~r;
                c_we     = 1'b1;
                flags_we = 1'b1;
            end
            OP_ADD: begin
                wide     = {1'b0, c} + {1'b0, r};
                result   = wide[DATA_W-1:0];
                cf_out   = wide[DATA_W];
                c_we     = 1'b1;
                flags_we = 1'b1;
            end
            OP_SUB: begin
                // The ninth bit of a zero-extended subtraction is the unsigned borrow.
                wide     = {1'b0, c} - {1'b0, r};
                result   = wide[DATA_W-1:0];
                cf_out   = wide[DATA_W];
                c_we     = 1'b1;
                flags_we = 1'b1;
            end
            OP_AND, OP_OR, OP_XOR: begin
                result   = (op == OP_AND) ? (c & r) : (op == OP_OR) ? (c | r) : (c ^ r);
                cf_out   = 1'b0;
                c_we     = 1'b1;
                flags_we = 1'b1;
            end
            OP_SHIFT: begin
                result   = d ? {1'b0, c[DATA_W-1:1]} : {c[DATA_W-2:0], 1'b0};
                cf_out   = d ? c[0] : c[DATA_W-1];
                c_we     = 1'b1;
                flags_we = 1'b1;
            end
            OP_INC: begin
                wide     = {1'b0, c} + 9'd1;
                result   = wide[DATA_W-1:0];
                cf_out   = wide[DATA_W];
                c_we     = 1'b1;
                flags_we = 1'b1;
            end
            OP_DEC: begin
                result   = c - 8'd1;
                cf_out   = (c == '0);
                c_we     = 1'b1;
                flags_we = 1'b1;
            end
            default: ;
        endcase
    end

    assign zf_out = (result == '0);

endmodule

// File: rtl/cpu_8bit.sv
// rtl/cpu_8bit.sv - single-cycle accumulator CPU: decode, register file, accumulator and flags
module cpu_8bit
    import cpu_8bit_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        iBus,
    output logic [DATA_W-1:0] acc,
    output logic              zf,
    output logic              cf
);

    logic [DATA_W-1:0] rf [REG_N];

    logic [3:0]        op;
    logic              d;
    logic [2:0]        n;
    logic [3:0]        imm;
    logic [DATA_W-1:0] alu_result;
    logic              alu_cf;
    logic              alu_zf;
    logic              c_we;
    logic              flags_we;

    assign op  = iBus[OP_MSB:OP_LSB];
    assign d   = iBus[D_BIT];
    assign n   = iBus[N_MSB:0];
    assign imm = iBus[IMM_MSB:0];

    cpu_8bit_alu u_alu (
        .op       (op),
        .d        (d),
        .c        (acc),
        .r        (rf[n]),
        .cf_in    (cf),
        .result   (alu_result),
        .cf_out   (alu_cf),
        .zf_out   (alu_zf),
        .c_we     (c_we),
        .flags_we (flags_we)
    );

    // Immediate loads bypass the ALU since they never touch the flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc <= '0;
            zf  <= 1'b0;
            cf  <= 1'b0;
            for (int i = 0; i < REG_N; i++) begin
                rf[i] <= '0;
            end
        end else begin
            if (op == OP_LDI) begin
                acc <= {4'h0, imm};
            end else if (op == OP_LDH) begin
                acc <= {imm, acc[3:0]};
            end else if (c_we) begin
                acc <= alu_result;
            end
            if (flags_we) begin
                zf <= alu_zf;
                cf <= alu_cf;
            end
            if (op == OP_MOV && d) begin
                rf[n] <= acc;
            end
        end
    end

endmodule

// File: tb/tb_cpu_8bit.sv
// tb/tb_cpu_8bit.sv - randomized self-checking bench for cpu_8bit against an arithmetic model
module tb_cpu_8bit;

    logic       clk;
    logic       rst;
    logic [7:0] ibus;
    logic [7:0] acc;
    logic       zf;
    logic       cf;

    int tests = 0;
    int fails = 0;

    int m_acc;
    int m_zf;
    int m_cf;
    int m_r [8];

    cpu_8bit dut (
        .clk  (clk),
        .rst  (rst),
        .iBus (ibus),
        .acc  (acc),
        .zf   (zf),
        .cf   (cf)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_acc = 0;
        m_zf  = 0;
        m_cf  = 0;
        for (int i = 0; i < 8; i++) m_r[i] = 0;
    endtask

    task automatic model_exec(input logic [7:0] ins);
        int op, dd, n, imm, rv, s;
        op  = ins / 16;
        dd  = (ins / 8) % 2;
        n   = ins % 8;
        imm = ins % 16;
        rv  = m_r[n];
        case (op)
            0: if (dd == 0) m_acc = rv; else m_r[n] = m_acc;
            1: m_acc = imm;
            2: m_acc = imm * 16 + (m_acc % 16);
            3: m_acc = 255 - rv;
            4: begin s = m_acc + rv; m_cf = (s > 255); m_acc = s % 256; end
            5: begin m_cf = (m_acc < rv); m_acc = (m_acc - rv + 256) % 256; end
            6: begin m_acc = m_acc & rv; m_cf = 0; end
            7: begin m_acc = m_acc | rv; m_cf = 0; end
            8: begin m_acc = m_acc ^ rv; m_cf = 0; end
            9: if (dd == 0) begin
                   m_cf = (m_acc >= 128); m_acc = (m_acc * 2) % 256;
               end else begin
                   m_cf = m_acc % 2; m_acc = m_acc / 2;
               end
            10: begin s = m_acc + 1; m_cf = (s == 256); m_acc = s % 256; end
            11: begin m_cf = (m_acc == 0); m_acc = (m_acc + 255) % 256; end
            default: ;
        endcase
        if (op >= 3 && op <= 11) m_zf = (m_acc == 0);
    endtask

    task automatic exec(input logic [7:0] ins);
        @(negedge clk);
        ibus = ins;
        model_exec(ins);
        @(posedge clk);
        #1;
        check($sformatf("acc after %02h", ins), 32'(acc), 32'(m_acc));
        check($sformatf("zf after %02h", ins), 32'(zf), 32'(m_zf));
        check($sformatf("cf after %02h", ins), 32'(cf), 32'(m_cf));
    endtask

    task automatic check_regs(input string tag);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("%s r%0d", tag, i), 32'(dut.rf[i]), 32'(m_r[i]));
        end
    endtask

    task automatic async_reset();
        @(posedge clk);
        #2;
        rst  = 1'b0;
        ibus = 8'h1F;
        #1;
        model_reset();
        check("async acc", 32'(acc), 32'h0);
        check("async zf", 32'(zf), 32'h0);
        check("async cf", 32'(cf), 32'h0);
        check_regs("async");
        @(posedge clk);
        #1;
        check("held acc", 32'(acc), 32'h0);
        @(negedge clk);
        rst  = 1'b1;
        ibus = 8'hC0;
    endtask

    initial begin
        rst  = 1'b0;
        ibus = 8'h00;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset acc", 32'(acc), 32'h0);
        check("reset zf", 32'(zf), 32'h0);
        check("reset cf", 32'(cf), 32'h0);
        check_regs("reset");
        @(negedge clk);
        rst  = 1'b1;
        ibus = 8'hC0;

        exec(8'h15); check("tp ldi", 32'(acc), 32'h05);
        exec(8'h08);
        exec(8'h00); check("tp mov", 32'(acc), 32'h05);
        exec(8'h09);
        exec(8'h31); check("tp not", 32'(acc), 32'hFA);
        check("tp not r1", 32'(dut.rf[1]), 32'h05);
        exec(8'h0A); check("tp r2", 32'(dut.rf[2]), 32'hFA);
        exec(8'h41); check("tp add", 32'(acc), 32'hFF); check("tp add cf", 32'(cf), 32'h0);
        exec(8'hA0); check("tp inc wrap", 32'({cf, zf, acc}), 32'h300);
        exec(8'h15); exec(8'h08); exec(8'h13);
        exec(8'h50); check("tp sub borrow", 32'({cf, acc}), 32'h1FE);
        exec(8'h00);
        exec(8'h50); check("tp sub equal", 32'({cf, zf, acc}), 32'h100);
        exec(8'h15);
        exec(8'h2A); check("tp ldh", 32'(acc), 32'hA5);
        exec(8'h90); check("tp shl", 32'({cf, acc}), 32'h14A);
        exec(8'h98); check("tp shr", 32'({cf, acc}), 32'h025);
        exec(8'hB8);
        check_regs("pre nop");
        for (int i = 8'hC0; i <= 8'hF7; i++) exec(8'(i));
        check_regs("nop");

        for (int i = 0; i < 8; i++) begin
            exec(8'h10 | 8'($urandom_range(0, 15)));
            exec(8'h20 | 8'($urandom_range(0, 15)));
            exec(8'h08 | 8'(i));
        end
        check_regs("loaded");
        async_reset();

        for (int k = 0; k < 500; k++) begin
            if ($urandom_range(0, 59) == 0) begin
                async_reset();
            end else begin
                exec(8'({$urandom_range(0, 12), 4'($urandom_range(0, 15))}));
            end
            if (k % 50 == 49) check_regs("rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/cpu_8bit.md
# cpu_8bit

Minimal single-cycle 8-bit accumulator CPU core. It executes one 8-bit instruction per clock, taken from an external instruction bus. State is an 8-bit accumulator C, an eight-entry 8-bit register file r0–r7 and zero/carry flags. It has no memory or program counter: the enclosing system or the bench drives each instruction directly onto `iBus`.

## Interface
- No parameters; data width fixed at 8 bits, register count fixed at 8.
- `clk`  input  1  rising-edge clock.
- `rst`  input  1  asynchronous, active-low reset.
- `iBus`  input  8  instruction word, sampled every rising edge.
- `acc`  output  8  current accumulator C, direct register output.
- `zf`  output  1  zero flag.
- `cf`  output  1  carry/borrow flag.
- Port order is `clk`, `rst`, `iBus`, `acc`, `zf`, `cf`, so two-port positional instantiation of (`clk`, `rst`) stays legal.

## Operation
Instruction format: `op = iBus[7:4]`, `d = iBus[3]`, `n = iBus[2:0]` (register index), `imm = iBus[3:0]`.
- 0x0 MOV: if `d`=0, C ← r[n]; if `d`=1, r[n] ← C. Flags unchanged.
- 0x1 LDI: C ← {4'h0, imm}. Flags unchanged.
- 0x2 LDH: C[7:4] ← imm; C[3:0] kept. Flags unchanged.
- 0x3 NOT: C ← ~r[n]; r[n] is unchanged. zf updated; cf unchanged.
- 0x4 ADD: {cf, C} ← C + r[n] (9-bit sum); zf updated.
- 0x5 SUB: C ← C − r[n]; cf ← 1 when C < r[n] (borrow), both unsigned; zf updated.
- 0x6 AND, 0x7 OR, 0x8 XOR: C ← C op r[n]; zf updated; cf ← 0.
- 0x9 SHIFT: C is the source and r[n] is unused.
  - `d`=0 shifts left: cf ← C[7], C ← {C[6:0], 0}.
  - `d`=1 shifts right: cf ← C[0], C ← {0, C[7:1]}.
  - zf updated.
- 0xA INC: {cf, C} ← C + 1; zf updated.
- 0xB DEC: C ← C − 1; cf ← (C == 0); zf updated.
- 0xC–0xF NOP: no state change. `iBus` = 8'h00 is MOV r0→C, not a NOP.
- In 0x3–0x8, bit `d` is ignored.
- zf ← (new C == 0) whenever an instruction updates it.
- Arithmetic is modulo 256, with wrap-around (0xFF+1 → 0x00, cf=1).
- Only one destination is written per instruction, so no write conflicts are possible.

## Timing
- Single-cycle: `iBus` is decoded combinationally and sampled at the rising edge of `clk`. All results are visible on `acc`/flags, and in r[n], immediately after that edge.
- A following instruction that reads a register sees the value written by the previous instruction. No hazards and no stalls.
- `iBus` must be stable around the rising edge; the bench changes it on the falling edge.
- Reset:
  - `rst`=0 asynchronously clears C, r0–r7, zf and cf to 0.
  - While `rst` is held low, `iBus` is ignored.
  - Reset asserted mid-stream discards the instruction on that edge.
  - The first instruction executed is the one present at the first rising edge with `rst`=1.
- `acc` after reset: 8'h00.

## Structure
- Shared package `cpu_8bit_pkg`: opcode constants (OP_MOV … OP_DEC, OP_NOP), field bit positions, data width constant 8.
- One sub-module, `cpu_8bit_alu`: purely combinational.
  - Inputs: op, d, C, r[n], cf.
  - Outputs: result, new cf, new zf, write-enables for C and flags.
- Top level holds the register file, C, the flags, the decoder and the register write-back.

## Test plan
- Reset then load/move sequence:
  - 0x15 → acc=0x05.
  - 0x08 → r0=0x05.
  - 0x00 → acc=0x05.
  - 0x09 → r1=0x05.
  - 0x31 → acc=0xFA, r1 still 0x05, zf=0.
  - 0x0A → r2=0xFA.
- ADD carry: C=0xFA, r1=0x05.
  - Add 0x41 → acc=0xFF, cf=0.
  - Then 0xA0 → acc=0x00, cf=1, zf=1.
- SUB borrow: C=0x03, r0=0x05.
  - 0x50 → acc=0xFE, cf=1.
  - Equal operands → acc=0x00, zf=1, cf=0.
- Logic/shift:
  - LDH 0x2A with C=0x05 → acc=0xA5.
  - 0x90 → acc=0x4A, cf=1.
  - 0x98 → acc=0x25, cf=0.
- NOP: 0xC0–0xF7 applied → acc, r0–r7 and flags all unchanged.
- Asynchronous reset: pull `rst` low between edges after loading r0–r7 → acc=0 and all registers/flags 0 before the next edge; an instruction held on `iBus` during reset has no effect.
